audio_channel: RTL and testbench
================================

# audio_channel

Single POKEY audio channel: an 8-bit reloadable divider clocked by a base-clock tick, a distortion stage that samples the 4-bit, 5-bit and 9/17-bit polynomial bits at each divider underflow, an optional high-pass flip-flop, and a 4-bit volume output. It is the consumer end of the polynomial core's poly-bit interface. Four instances sit between the polynomial core and the audio mixer.

## Interface
Parameters:
- none.

Ports:
- clk  input  1  system clock; all state changes on negedge clk, same as the polynomial core.
- reset  input  1  asynchronous, active-high.
- enn  input  1  master clock enable; state advances only when enn=1 at the clk edge, except for reset.
- baseTick  input  1  divider count enable from the base-clock prescaler; qualified by enn.
- stimer  input  1  STIMER write strobe; qualified by enn.
- audf  input  8  AUDF frequency register.
- audc  input  8  AUDC: [7:5] distortion, [4] volume-only, [3:0] volume.
- poly4bit  input  1  4-bit polynomial output.
- poly5bit  input  1  5-bit polynomial output.
- poly917bit  input  1  9/17-bit polynomial output.
- hpEn  input  1  AUDCTL high-pass enable for this channel.
- hpClk  input  1  underflow pulse from the partner channel that clocks the high-pass flip-flop.
- underflow  output  1  one-cycle pulse when the divider reloads on count.
- chanOut  output  1  channel square or noise bit after the high-pass stage.
- volOut  output  4  channel volume to the mixer.

## Operation
- Divider: 8-bit `count`. On an enabled edge with baseTick=1:
  - if count==0: count<=audf and underflow<=1.
  - else: count<=count-1 and underflow<=0.
  - Period is audf+1 ticks. audf=0 gives an underflow on every tick.
- underflow<=0 on any enabled edge without a reload.
- stimer=1: count<=audf, tone FF<=0, hp FF<=0, underflow<=0. stimer has priority over a simultaneous baseTick.
- Distortion, evaluated at the same edge that sets underflow. Poly inputs are sampled on that edge.
  - gate = audc[7] | poly5bit.
  - src = audc[5] ? ~toneFF : (audc[6] ? poly4bit : poly917bit).
  - If gate=1: toneFF<=src. Otherwise toneFF holds.
- High-pass: on an enabled edge with hpClk=1, hpFF<=toneFF. hpClk and an own underflow in the same cycle: hpFF captures the old toneFF.
- chanOut = hpEn ? (toneFF ^ hpFF) : toneFF. This is combinational from registers.
- volOut is combinational:
  - audc[4]=1: volOut=audc[3:0] (volume-only).
  - audc[4]=0: volOut = chanOut ? audc[3:0] : 0.
- audf changes mid-count take effect at the next reload or stimer only.

## Timing
- Reset values: count=0, toneFF=0, hpFF=0, underflow=0. Hence chanOut=0, and volOut=0 unless audc[4]=1.
- The first baseTick after reset underflows immediately, because count=0.
- Latency: underflow and toneFF update on the same edge, one edge after baseTick is seen.
- volOut follows audc changes combinationally, with zero latency.
- Reset asserted mid-count clears all state immediately. Counting resumes on the first enabled edge after release.
- enn=0 freezes all state. baseTick and stimer pulses presented while enn=0 are lost.

## Configuration
- POKEY_HIPASS_EN defined: hpFF and the XOR stage are present as described.
- POKEY_HIPASS_EN undefined:
  - hpFF is removed.
  - hpEn and hpClk are ignored; the ports remain for a pin-compatible instance.
  - chanOut = toneFF.

## Structure
- Package pokey_pkg holds:
  - AUDC bit-index constants: DIST_NO5, DIST_SEL4, DIST_PURE, VOL_ONLY, VOL_MSB/LSB.
  - The 8-bit `audf_t` typedef.
- Sub-module chan_divider holds the count register, reload, stimer priority and underflow pulse. audio_channel instantiates it and holds the distortion, high-pass and volume logic.

## Test plan
- audf=3, audc=0xA8 (pure tone, vol 8), baseTick every cycle:
  - underflow every 4 cycles.
  - chanOut toggles at each underflow, giving period 8.
  - volOut alternates 8/0.
- audc=0x1F with any audf: volOut=0xF constantly, including straight after reset.
- audc=0x48 (poly5 gated, poly4 source), poly5bit forced 0: toneFF never changes. With poly5bit=1 and poly4bit=1 at an underflow: toneFF=1.
- stimer asserted in the same cycle as baseTick with count=0:
  - no underflow.
  - count=audf.
  - toneFF=0.
- POKEY_HIPASS_EN defined, hpEn=1, pure tone, hpClk pulsed while toneFF=1: chanOut goes 0. After the next own underflow, chanOut goes 1.
- Reset asserted mid-count (count=5, toneFF=1): count=0, chanOut=0 and underflow=0 immediately. The first enabled baseTick after release produces underflow.

Source files
------------

// File: rtl/pokey_pkg.sv
// Shared POKEY definitions: AUDC bit positions and the AUDF register type.
package pokey_pkg;

  localparam int unsigned DIST_NO5  = 7;
  localparam int unsigned DIST_SEL4 = 6;
  localparam int unsigned DIST_PURE = 5;
  localparam int unsigned VOL_ONLY  = 4;
  localparam int unsigned VOL_MSB   = 3;
  localparam int unsigned VOL_LSB   = 0;

  typedef logic [7:0] audf_t;

endpackage

// File: rtl/chan_divider.sv
// Audio channel 8-bit reloadable divider with STIMER restart and underflow pulse.
module chan_divider
  import pokey_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enn,
  input  logic       baseTick,
  input  logic       stimer,
  input  logic [7:0] audf,
  output logic       reload,
  output logic       underflow
);

  audf_t count;

  // Reload-on-count qualifier; the parent samples its distortion on this same edge.
  assign reload = enn & baseTick & ~stimer & (count == '0);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      underflow <= 1'b0;
    end else if (enn) begin
      underflow <= reload;
      if (stimer) begin
        count <= audf;
      end else if (baseTick) begin
        if (count == '0) count <= audf;
        else             count <= count - 8'd1;
      end
    end
  end

endmodule

// File: rtl/audio_channel.sv
// Single POKEY audio channel: divider, distortion, optional high-pass, volume.
// Macro POKEY_HIPASS_EN enables the high-pass flip-flop and XOR stage.
module audio_channel
  import pokey_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enn,
  input  logic       baseTick,
  input  logic       stimer,
  input  logic [7:0] audf,
  input  logic [7:0] audc,
  input  logic       poly4bit,
  input  logic       poly5bit,
  input  logic       poly917bit,
  input  logic       hpEn,
  input  logic       hpClk,
  output logic       underflow,
  output logic       chanOut,
  output logic [3:0] volOut
);

  logic reload;
  logic tone_ff;
  logic gate;
  logic src;

  chan_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .enn       (enn),
    .baseTick  (baseTick),
    .stimer    (stimer),
    .audf      (audf),
    .reload    (reload),
    .underflow (underflow)
  );

  always_comb begin
    gate = audc[DIST_NO5] | poly5bit;
    src  = audc[DIST_PURE] ? ~tone_ff
                           : (audc[DIST_SEL4] ? poly4bit : poly917bit);
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      tone_ff <= 1'b0;
    end else if (enn) begin
      if (stimer)              tone_ff <= 1'b0;
      else if (reload && gate) tone_ff <= src;
    end
  end

`ifdef POKEY_HIPASS_EN
  logic hp_ff;

  // Captures the pre-edge tone value even when the own underflow fires together.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      hp_ff <= 1'b0;
    end else if (enn) begin
      if (stimer)     hp_ff <= 1'b0;
      else if (hpClk) hp_ff <= tone_ff;
    end
  end

  assign chanOut = hpEn ? (tone_ff ^ hp_ff) : tone_ff;
`else
  logic unused_hp;
  assign unused_hp = hpEn ^ hpClk;
  assign chanOut   = tone_ff;
`endif

  always_comb begin
    if (audc[VOL_ONLY]) volOut = audc[VOL_MSB:VOL_LSB];
    else if (chanOut)   volOut = audc[VOL_MSB:VOL_LSB];
    else                volOut = '0;
  end

endmodule

// File: tb/tb_audio_channel.sv
// Self-checking bench for audio_channel: reference model plus directed literal checks.
module tb_audio_channel;

`ifdef POKEY_HIPASS_EN
  localparam bit HP_BUILD = 1'b1;
`else
  localparam bit HP_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enn = 1'b1;
  logic       baseTick = 1'b0;
  logic       stimer = 1'b0;
  logic [7:0] audf = 8'd0;
  logic [7:0] audc = 8'd0;
  logic       poly4bit = 1'b0;
  logic       poly5bit = 1'b0;
  logic       poly917bit = 1'b0;
  logic       hpEn = 1'b0;
  logic       hpClk = 1'b0;
  logic       underflow;
  logic       chanOut;
  logic [3:0] volOut;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  audio_channel dut (
    .clk        (clk),
    .reset      (reset),
    .enn        (enn),
    .baseTick   (baseTick),
    .stimer     (stimer),
    .audf       (audf),
    .audc       (audc),
    .poly4bit   (poly4bit),
    .poly5bit   (poly5bit),
    .poly917bit (poly917bit),
    .hpEn       (hpEn),
    .hpClk      (hpClk),
    .underflow  (underflow),
    .chanOut    (chanOut),
    .volOut     (volOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: ticks remaining before the next reload, tone and high-pass bits.
  int ticks_left;
  bit m_tone, m_hp, m_uf;

  always @(negedge clk or posedge reset) begin
    bit prev_tone;
    if (reset) begin
      ticks_left = 0; m_tone = 0; m_hp = 0; m_uf = 0;
    end else if (enn) begin
      prev_tone = m_tone;
      m_uf = 0;
      if (stimer) begin
        ticks_left = audf; m_tone = 0; m_hp = 0;
      end else begin
        if (HP_BUILD && hpClk) m_hp = prev_tone;
        if (baseTick) begin
          if (ticks_left == 0) begin
            ticks_left = audf;
            m_uf = 1;
            if (audc[7] || poly5bit)
              m_tone = audc[5] ? !prev_tone : (audc[6] ? poly4bit : poly917bit);
          end else begin
            ticks_left = ticks_left - 1;
          end
        end
      end
    end
  end

  function automatic int model_chan();
    return (HP_BUILD && hpEn) ? int'(m_tone ^ m_hp) : int'(m_tone);
  endfunction

  function automatic int model_vol();
    if (audc[4] || model_chan() != 0) return int'(audc[3:0]);
    return 0;
  endfunction

  always @(posedge clk) begin
    if (checking) begin
      check("model_underflow", int'(underflow), int'(m_uf));
      check("model_chanOut", int'(chanOut), model_chan());
      check("model_volOut", int'(volOut), model_vol());
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [7:0] dist_tbl [7] = '{8'h08, 8'h28, 8'h48, 8'h68, 8'h88, 8'hC8, 8'hE8};

  initial begin
    step();
    checking = 1'b1;

    // Reset state
    check("reset_underflow", int'(underflow), 0);
    check("reset_chanOut", int'(chanOut), 0);
    check("reset_volOut", int'(volOut), 0);

    // Pure tone, audf=3: underflow every 4 ticks, chanOut period 8, vol 8/0
    audf = 8'd3; audc = 8'hA8;
    do_reset();
    baseTick = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check("tone_underflow", int'(underflow), (i % 4 == 0) ? 1 : 0);
      check("tone_chanOut", int'(chanOut), ((i / 4) % 2 == 0) ? 1 : 0);
      check("tone_volOut", int'(volOut), ((i / 4) % 2 == 0) ? 8 : 0);
    end

    // Volume-only: constant 0xF, also during reset
    baseTick = 1'b0;
    reset = 1'b1; audc = 8'h1F; audf = 8'd5;
    #1;
    check("volonly_in_reset", int'(volOut), 15);
    step();
    reset = 1'b0; baseTick = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("volonly_run", int'(volOut), 15);
    end

    // Poly5 gate closed: tone never changes; then poly5=1, poly4=1 sets it
    audf = 8'd0; audc = 8'h48; poly5bit = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      poly4bit = i[0]; poly917bit = ~i[0];
      step();
      check("gate_closed_chanOut", int'(chanOut), 0);
    end
    poly5bit = 1'b1; poly4bit = 1'b1;
    step();
    check("gate_open_underflow", int'(underflow), 1);
    check("gate_open_chanOut", int'(chanOut), 1);

    // STIMER beats baseTick at count=0
    poly5bit = 1'b0; audf = 8'd0; audc = 8'hA8;
    do_reset();
    step();
    check("pre_stimer_chanOut", int'(chanOut), 1);
    audf = 8'd2; stimer = 1'b1;
    step();
    check("stimer_underflow", int'(underflow), 0);
    check("stimer_chanOut", int'(chanOut), 0);
    stimer = 1'b0;
    step(); check("post_stimer_uf1", int'(underflow), 0);
    step(); check("post_stimer_uf2", int'(underflow), 0);
    step(); check("post_stimer_uf3", int'(underflow), 1);
    check("post_stimer_chanOut", int'(chanOut), 1);

    // High-pass stage
    audf = 8'd3; audc = 8'hA8; hpEn = 1'b1;
    do_reset();
    step();
    check("hp_start_chanOut", int'(chanOut), 1);
    hpClk = 1'b1;
    step();
    hpClk = 1'b0;
`ifdef POKEY_HIPASS_EN
    check("hp_clocked_chanOut", int'(chanOut), 0);
    step(); step(); step();
    check("hp_own_uf", int'(underflow), 1);
    check("hp_after_uf_chanOut", int'(chanOut), 1);
`else
    check("hp_ignored_chanOut", int'(chanOut), 1);
    step(); step(); step();
    check("hp_ignored_uf", int'(underflow), 1);
    check("hp_ignored_after_uf", int'(chanOut), 0);
`endif
    hpEn = 1'b0;

    // Reset mid-count (count=5, tone=1)
    audf = 8'd9; audc = 8'hA8;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check("premid_chanOut", int'(chanOut), 1);
    reset = 1'b1;
    #1;
    check("midreset_underflow", int'(underflow), 0);
    check("midreset_chanOut", int'(chanOut), 0);
    check("midreset_volOut", int'(volOut), 0);
    step();
    reset = 1'b0;
    step();
    check("after_reset_underflow", int'(underflow), 1);

    // enn=0 freezes state and drops stimer/baseTick
    audf = 8'd1;
    do_reset();
    step();
    check("enn_pre_uf", int'(underflow), 1);
    enn = 1'b0; stimer = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("enn_frozen_uf", int'(underflow), 1);
      check("enn_frozen_chan", int'(chanOut), 1);
    end
    enn = 1'b1; stimer = 1'b0;
    step(); check("enn_resume_uf0", int'(underflow), 0);
    step(); check("enn_resume_uf1", int'(underflow), 1);
    check("enn_resume_chan", int'(chanOut), 0);

    // Distortion modes with varied poly bits, model-checked
    hpEn = 1'b1;
    foreach (dist_tbl[k]) begin
      audc = dist_tbl[k];
      audf = 8'(k % 3);
      for (int i = 0; i < 12; i++) begin
        poly4bit = $urandom_range(0, 1);
        poly5bit = $urandom_range(0, 1);
        poly917bit = $urandom_range(0, 1);
        hpClk = $urandom_range(0, 1);
        baseTick = (i % 5 != 4);
        step();
      end
    end
    hpClk = 1'b0;
    step();

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
